nios2_debug_ocimem_engine: RTL and testbench
============================================

Name: nios2_debug_ocimem_engine

Overview:
- Consumes the sysclk-domain JTAG debug command stream (jdo plus take_action_ocimem_* / take_no_action_ocimem_a pulses) produced by the CPU debug slave wrapper.
- Executes single-word reads and writes on the on-chip debug memory through a simple waitrequest-based master port, with address auto-increment.
- Returns the result to the wrapper through MonDReg, monitor_ready and monitor_error.

Parameters:
- ADDR_W, 8: debug memory word-address width; address wraps modulo 2^ADDR_W.
- TIMEOUT, 255: maximum stalled cycles per access before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; asynchronous, active-low
- jdo  in  38  JTAG data-out word, valid in any cycle where a take_* pulse is high
- take_action_ocimem_a  in  1  1-cycle pulse: address/control command
- take_action_ocimem_b  in  1  1-cycle pulse: write command
- take_no_action_ocimem_a  in  1  1-cycle pulse: streaming read command
- MonDReg  out  32  last read data, or echoed write data
- monitor_ready  out  1  high when idle and the result is valid
- monitor_error  out  1  sticky error flag
- busy  out  1  access in progress
- mem_address  out  ADDR_W  word address
- mem_read  out  1  read request
- mem_write  out  1  write request
- mem_writedata  out  32  write data
- mem_readdata  in  32  read data, valid in the accept cycle
- mem_waitrequest  in  1  slave stall

Behaviour:
- Reset values:
  - MonDReg=0, monitor_ready=1, monitor_error=0, busy=0.
  - mem_address=0, mem_read=0, mem_write=0, mem_writedata=0.
  - Internal address register=0, timeout counter=0, state=IDLE.
- States: IDLE, READ, WRITE.
- Command decode (accepted only in IDLE):
  - take_action_ocimem_a:
    - addr <= jdo[ADDR_W+16:17].
    - If jdo[34]=1, monitor_error <= 0.
    - If jdo[35]=1, go to READ at the newly loaded address, with no increment first.
    - Otherwise stay in IDLE.
  - take_action_ocimem_b: mem_writedata <= jdo[31:0] and MonDReg <= jdo[31:0]; go to WRITE.
  - take_no_action_ocimem_a: go to READ at the current addr.
- Priority: take_action_ocimem_a > take_action_ocimem_b > take_no_action_ocimem_a. A lower-priority pulse in the same cycle is ignored silently, with no error.
- Command pulse while busy: the pulse is dropped, monitor_error <= 1, and the in-flight access is unaffected.
- State-entry cycle: mem_read or mem_write is asserted on the clock edge that enters READ/WRITE, and busy=1. monitor_ready falls in the same cycle.
- Completion: an access completes in the cycle where the request is high and mem_waitrequest=0.
  - READ: MonDReg <= mem_readdata.
  - Both: addr <= addr+1 (mod 2^ADDR_W); request deasserted; return to IDLE; monitor_ready=1 on the next cycle.
  - Minimum latency from pulse to monitor_ready is 2 clocks.
- mem_address always equals the internal addr register.
- Timeout (TIMEOUT>0):
  - The counter increments on each cycle with the request high and mem_waitrequest=1.
  - If the counter reaches TIMEOUT while waitrequest is still high: deassert the request next clock, monitor_error <= 1, MonDReg and addr unchanged, return to IDLE.
  - The counter clears on entering IDLE.
- Error: monitor_error is sticky until cleared via take_action_ocimem_a with jdo[34]=1. If a clear and a new error occur in the same cycle, the set wins.
- Reset mid-access: requests drop immediately (asynchronous). All registers return to reset values and no partial write is retried.

Test Plan:
- Reset, then pulse a with jdo[35]=1 and jdo[24:17]=0x10, waitrequest=0, readdata=0xDEADBEEF -> mem_read high 1 cycle at address 0x10; MonDReg=0xDEADBEEF; addr=0x11; monitor_ready=1 two clocks after the pulse.
- Pulse b with jdo[31:0]=0x12345678 at addr 0x11, waitrequest high 3 cycles -> mem_write held 4 cycles, writedata=0x12345678, addr=0x12, busy cleared, no error.
- addr=0xFF, pulse take_no_action_ocimem_a -> read at 0xFF, addr wraps to 0x00.
- waitrequest stuck high, TIMEOUT=255 -> request drops after the 255th stall, monitor_error=1, addr unchanged; a then pulse with jdo[34]=1 -> error=0.
- Pulse b during an in-flight READ -> write ignored, monitor_error=1, read completes normally.
- Assert reset_n=0 mid-WRITE -> mem_write=0 asynchronously; all outputs at reset values, monitor_ready=1.

Source files
------------

// File: rtl/nios2_debug_ocimem_engine.sv
// Debug-memory access engine: decodes JTAG ocimem commands into single-word
// reads/writes on a waitrequest master port and reports results back.
module nios2_debug_ocimem_engine #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    input  logic              mem_waitrequest
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t             r_state, w_state_nxt;
    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_mondreg;
    logic [31:0]        r_wdata;
    logic               r_error;
    logic [CNT_W-1:0]   r_cnt;

    logic w_any_take, w_stall, w_timeout;
    logic w_cmd_a, w_cmd_b, w_done, w_rd_done, w_err_set, w_err_clr;
    logic w_unused;

    assign w_any_take = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign w_stall    = (r_state != IDLE) && mem_waitrequest;
    assign w_timeout  = (TIMEOUT > 0) && w_stall && (r_cnt == CNT_LAST);
    assign w_err_clr  = w_cmd_a && jdo[34];
    assign w_rd_done  = w_done && (r_state == READ);
    assign w_unused   = &{1'b0, jdo};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cmd_a     = 1'b0;
        w_cmd_b     = 1'b0;
        w_done      = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            IDLE: begin
                // Fixed priority a > b > no_action; losers are dropped without error.
                if (take_action_ocimem_a) begin
                    w_cmd_a = 1'b1;
                    if (jdo[35]) w_state_nxt = READ;
                end else if (take_action_ocimem_b) begin
                    w_cmd_b     = 1'b1;
                    w_state_nxt = WRITE;
                end else if (take_no_action_ocimem_a) begin
                    w_state_nxt = READ;
                end
            end
            default: begin
                if (w_any_take) w_err_set = 1'b1;
                if (!mem_waitrequest) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_timeout) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr    <= '0;
            r_mondreg <= '0;
            r_wdata   <= '0;
            r_error   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if (w_cmd_a)     r_addr <= jdo[ADDR_W+16:17];
            else if (w_done) r_addr <= r_addr + ADDR_W'(1);

            if (w_cmd_b)        r_mondreg <= jdo[31:0];
            else if (w_rd_done) r_mondreg <= mem_readdata;

            if (w_cmd_b) r_wdata <= jdo[31:0];

            // A new error beats a same-cycle clear.
            if (w_err_set)      r_error <= 1'b1;
            else if (w_err_clr) r_error <= 1'b0;

            if (w_state_nxt == IDLE) r_cnt <= '0;
            else if (w_stall)        r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign MonDReg       = r_mondreg;
    assign monitor_ready = (r_state == IDLE);
    assign monitor_error = r_error;
    assign busy          = (r_state != IDLE);
    assign mem_address   = r_addr;
    assign mem_read      = (r_state == READ);
    assign mem_write     = (r_state == WRITE);
    assign mem_writedata = r_wdata;

endmodule

// File: tb/tb_nios2_debug_ocimem_engine.sv
// Directed bench for the ocimem engine: inputs driven and outputs sampled on
// the falling edge, one task per scenario.
module tb_nios2_debug_ocimem_engine;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [37:0] jdo = '0;
    logic        take_action_ocimem_a = 1'b0;
    logic        take_action_ocimem_b = 1'b0;
    logic        take_no_action_ocimem_a = 1'b0;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error, busy;
    logic [7:0]  mem_address;
    logic        mem_read, mem_write;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata = '0;
    logic        mem_waitrequest = 1'b0;

    int checks = 0;
    int errors = 0;

    nios2_debug_ocimem_engine #(.ADDR_W(8), .TIMEOUT(255)) dut (
        .clk(clk), .reset_n(reset_n), .jdo(jdo),
        .take_action_ocimem_a(take_action_ocimem_a),
        .take_action_ocimem_b(take_action_ocimem_b),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error),
        .busy(busy), .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .mem_waitrequest(mem_waitrequest)
    );

    always #5 clk = ~clk;

    // Drives one command cycle; returns on the following falling edge.
    task automatic pulse(input logic a, input logic b, input logic na, input logic [37:0] d);
        @(negedge clk);
        take_action_ocimem_a    = a;
        take_action_ocimem_b    = b;
        take_no_action_ocimem_a = na;
        jdo                     = d;
        @(negedge clk);
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
    endtask

    function automatic logic [37:0] jdo_a(input logic rd, input logic clr, input logic [7:0] addr);
        logic [37:0] v;
        v        = '0;
        v[35]    = rd;
        v[34]    = clr;
        v[24:17] = addr;
        return v;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({MonDReg, monitor_ready, monitor_error, busy} !== {32'h0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_status: got %h/%b%b%b want 00000000/100", MonDReg, monitor_ready, monitor_error, busy);
        end
        checks++;
        if ({mem_address, mem_read, mem_write, mem_writedata} !== {8'h0, 1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_mem: got addr=%h rd=%b wr=%b wd=%h want all zero", mem_address, mem_read, mem_write, mem_writedata);
        end
    endtask

    task automatic test_read_a();
        mem_waitrequest = 1'b0;
        mem_readdata    = 32'hDEADBEEF;
        pulse(1'b1, 1'b0, 1'b0, jdo_a(1'b1, 1'b0, 8'h10));
        checks++;
        if ({mem_read, mem_write, busy, monitor_ready, mem_address} !== {1'b1, 1'b0, 1'b1, 1'b0, 8'h10}) begin
            errors++;
            $display("FAIL read_a_entry: got rd=%b wr=%b busy=%b rdy=%b addr=%h want 1 0 1 0 10", mem_read, mem_write, busy, monitor_ready, mem_address);
        end
        @(negedge clk);
        checks++;
        if ({mem_read, busy, monitor_ready} !== 3'b001) begin
            errors++;
            $display("FAIL read_a_done: got rd=%b busy=%b rdy=%b want 0 0 1", mem_read, busy, monitor_ready);
        end
        checks++;
        if (MonDReg !== 32'hDEADBEEF || mem_address !== 8'h11) begin
            errors++;
            $display("FAIL read_a_data: got %h addr=%h want deadbeef addr=11", MonDReg, mem_address);
        end
    endtask

    task automatic test_write_stall();
        int n;
        n = 0;
        mem_waitrequest = 1'b1;
        pulse(1'b0, 1'b1, 1'b0, {6'h0, 32'h12345678});
        for (int g = 0; g < 20 && mem_write; g++) begin
            n++;
            if (n == 4) mem_waitrequest = 1'b0;
            checks++;
            if (mem_writedata !== 32'h12345678) begin
                errors++;
                $display("FAIL write_data: got %h want 12345678", mem_writedata);
            end
            @(negedge clk);
        end
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL write_cycles: got %0d want 4", n);
        end
        checks++;
        if ({mem_address, busy, monitor_error, monitor_ready} !== {8'h12, 1'b0, 1'b0, 1'b1} || MonDReg !== 32'h12345678) begin
            errors++;
            $display("FAIL write_done: got addr=%h busy=%b err=%b rdy=%b mon=%h want 12 0 0 1 12345678", mem_address, busy, monitor_error, monitor_ready, MonDReg);
        end
    endtask

    task automatic test_priority();
        // a (no read) wins over b in the same cycle: only the address loads.
        pulse(1'b1, 1'b1, 1'b0, jdo_a(1'b0, 1'b0, 8'hFF) | 38'h0_AAAA_AAAA);
        checks++;
        if ({busy, mem_write, monitor_error, mem_address} !== {1'b0, 1'b0, 1'b0, 8'hFF} || MonDReg !== 32'h12345678) begin
            errors++;
            $display("FAIL priority: got busy=%b wr=%b err=%b addr=%h mon=%h want 0 0 0 ff 12345678", busy, mem_write, monitor_error, mem_address, MonDReg);
        end
    endtask

    task automatic test_wrap();
        mem_waitrequest = 1'b0;
        mem_readdata    = 32'hCAFEF00D;
        pulse(1'b0, 1'b0, 1'b1, '0);
        checks++;
        if (mem_read !== 1'b1 || mem_address !== 8'hFF) begin
            errors++;
            $display("FAIL wrap_entry: got rd=%b addr=%h want 1 ff", mem_read, mem_address);
        end
        @(negedge clk);
        checks++;
        if (mem_address !== 8'h00 || MonDReg !== 32'hCAFEF00D || monitor_ready !== 1'b1) begin
            errors++;
            $display("FAIL wrap_done: got addr=%h mon=%h rdy=%b want 00 cafef00d 1", mem_address, MonDReg, monitor_ready);
        end
    endtask

    task automatic test_timeout();
        int n;
        n = 0;
        mem_waitrequest = 1'b1;
        mem_readdata    = 32'h11111111;
        pulse(1'b0, 1'b0, 1'b1, '0);
        for (int g = 0; g < 400 && mem_read; g++) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== 255) begin
            errors++;
            $display("FAIL timeout_cycles: got %0d want 255", n);
        end
        checks++;
        if ({monitor_error, busy, monitor_ready, mem_address} !== {1'b1, 1'b0, 1'b1, 8'h00} || MonDReg !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL timeout_state: got err=%b busy=%b rdy=%b addr=%h mon=%h want 1 0 1 00 cafef00d", monitor_error, busy, monitor_ready, mem_address, MonDReg);
        end
        mem_waitrequest = 1'b0;
        pulse(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 1'b1, 8'h05));
        checks++;
        if (monitor_error !== 1'b0 || mem_address !== 8'h05) begin
            errors++;
            $display("FAIL error_clear: got err=%b addr=%h want 0 05", monitor_error, mem_address);
        end
    endtask

    task automatic test_busy_pulse();
        mem_waitrequest = 1'b1;
        pulse(1'b0, 1'b0, 1'b1, '0);
        pulse(1'b0, 1'b1, 1'b0, {6'h0, 32'hAAAA5555});
        checks++;
        if ({monitor_error, mem_read, mem_write, mem_address} !== {1'b1, 1'b1, 1'b0, 8'h05}) begin
            errors++;
            $display("FAIL busy_pulse: got err=%b rd=%b wr=%b addr=%h want 1 1 0 05", monitor_error, mem_read, mem_write, mem_address);
        end
        mem_waitrequest = 1'b0;
        mem_readdata    = 32'h0BADC0DE;
        @(negedge clk);
        checks++;
        if (MonDReg !== 32'h0BADC0DE || mem_address !== 8'h06 || mem_writedata !== 32'h12345678 || monitor_error !== 1'b1) begin
            errors++;
            $display("FAIL busy_read_done: got mon=%h addr=%h wd=%h err=%b want 0badc0de 06 12345678 1", MonDReg, mem_address, mem_writedata, monitor_error);
        end
    endtask

    task automatic test_reset_mid_write();
        mem_waitrequest = 1'b1;
        pulse(1'b0, 1'b1, 1'b0, {6'h0, 32'h55AA55AA});
        checks++;
        if (mem_write !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: got wr=%b want 1", mem_write);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({mem_write, mem_read, busy, monitor_ready, monitor_error} !== 5'b00010) begin
            errors++;
            $display("FAIL rst_async: got wr=%b rd=%b busy=%b rdy=%b err=%b want 0 0 0 1 0", mem_write, mem_read, busy, monitor_ready, monitor_error);
        end
        checks++;
        if (MonDReg !== 32'h0 || mem_writedata !== 32'h0 || mem_address !== 8'h0) begin
            errors++;
            $display("FAIL rst_regs: got mon=%h wd=%h addr=%h want 0 0 0", MonDReg, mem_writedata, mem_address);
        end
        mem_waitrequest = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_retry: got busy=%b wr=%b want 0 0", busy, mem_write);
        end
    endtask

    initial begin
        test_reset();
        test_read_a();
        test_write_stall();
        test_priority();
        test_wrap();
        test_timeout();
        test_busy_pulse();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
